// File: rtl/wdata_chan_rcvr_pkg.sv
// rtl/wdata_chan_rcvr_pkg.sv - shared encodings and widths for the write-data channel receiver
package wdata_chan_rcvr_pkg;

    localparam int DEF_BURST_LEN = 4;
    localparam int DATA_W        = 32;
    localparam int STRB_W        = DATA_W / 8;
    localparam int LINE_W        = 128;
    localparam int MASK_W        = LINE_W / 8;
    localparam int ID_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/wdata_chan_rcvr.sv
// rtl/wdata_chan_rcvr.sv - gathers a four-beat write burst into one 128-bit line with byte mask
module wdata_chan_rcvr
    import wdata_chan_rcvr_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              start_rq,
    input  logic [ID_W-1:0]   start_id,
    output logic              start_ack,
    output logic              wd_valid,
    input  logic              wd_ready,
    output logic [LINE_W-1:0] wd_data,
    output logic [MASK_W-1:0] wd_mask,
    output logic [ID_W-1:0]   wd_id,
    output logic              wd_err
);

    // Only BURST_LEN == 4 is meaningful: the counter and line slicing assume four beats.
    localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] beat_cnt;
    logic       beat_acc;
    logic       is_last;

    assign beat_acc = wvalid & wready;
    assign is_last  = (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_rq) state_nxt = ST_RECV;
            ST_RECV: if (beat_acc && is_last) state_nxt = ST_HOLD;
            ST_HOLD: if (wd_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wready    = 1'b0;
        wd_valid  = 1'b0;
        start_ack = 1'b0;
        case (state)
            ST_IDLE: start_ack = start_rq;
            ST_RECV: wready    = 1'b1;
            ST_HOLD: wd_valid  = 1'b1;
            default: ;
        endcase
    end

    // Beat k lands in lane k; wd_data is not cleared on start since all four lanes get rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 2'd0;
            wd_data  <= '0;
            wd_mask  <= '0;
            wd_id    <= '0;
            wd_err   <= 1'b0;
        end else if (state == ST_IDLE && start_rq) begin
            beat_cnt <= 2'd0;
            wd_mask  <= '0;
            wd_id    <= start_id;
            wd_err   <= 1'b0;
        end else if (beat_acc) begin
            wd_data[{beat_cnt, 5'd0} +: DATA_W] <= wdata;
            wd_mask[{beat_cnt, 2'd0} +: STRB_W] <= wstrb;
            beat_cnt <= beat_cnt + 2'd1;
            if (wlast != is_last) begin
                wd_err <= 1'b1;
            end
        end
    end

endmodule
